// File: rtl/attn_matmul_engine.sv
// Single-MAC matrix-multiply engine: C = A x B or A x B^T over 1-cycle SRAM read ports.
// Optional output clamping and sticky sat_flag are compiled in with `define ATTN_MATMUL_SAT_EN.
module attn_matmul_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 12,
  parameter int ACC_W  = 64,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DIM_W-1:0]  cfg_rows_a,
  input  logic [DIM_W-1:0]  cfg_cols_a,
  input  logic [DIM_W-1:0]  cfg_cols_b,
  input  logic [ADDR_W-1:0] cfg_a_base,
  input  logic [ADDR_W-1:0] cfg_b_base,
  input  logic [ADDR_W-1:0] cfg_c_base,
  input  logic              cfg_transpose_b,
  output logic [ADDR_W-1:0] a_rd_addr,
  input  logic [DATA_W-1:0] a_rd_data,
  output logic [ADDR_W-1:0] b_rd_addr,
  input  logic [DATA_W-1:0] b_rd_data,
  output logic              c_wr_en,
  output logic [ADDR_W-1:0] c_wr_addr,
  output logic [DATA_W-1:0] c_wr_data,
  output logic              busy,
  output logic              done,
  output logic              sat_flag
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;

  logic [DIM_W-1:0]  i_cnt, j_cnt, k_cnt, i_max, j_max, k_max;
  logic [ADDR_W-1:0] a_row, b_col, b_base_r, b_step, c_addr, b_next_col;
  logic              transpose_r, drain_cnt;
  logic              p1_valid, p1_first, p1_last;
  logic [ACC_W-1:0]  acc, prod_ext, sum;
  logic [2*DATA_W-1:0]        prod_u;
  logic signed [2*DATA_W-1:0] prod_s;
  logic [DATA_W-1:0] out_val;
  logic              k_last, j_last, i_last, accept, zero_dim;

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign accept      = start_valid && (state == IDLE);
  assign zero_dim    = (cfg_rows_a == '0) || (cfg_cols_a == '0) || (cfg_cols_b == '0);

  assign k_last = (k_cnt == k_max);
  assign j_last = (j_cnt == j_max);
  assign i_last = (i_cnt == i_max);

  // Start of the next B column: contiguous after the last row in transpose mode.
  assign b_next_col = transpose_r ? b_rd_addr + 1'b1 : b_col + 1'b1;

  // Sequencer: walks i/j/k and issues one A/B read pair per RUN cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state       <= IDLE;
      i_cnt       <= '0;
      j_cnt       <= '0;
      k_cnt       <= '0;
      i_max       <= '0;
      j_max       <= '0;
      k_max       <= '0;
      a_rd_addr   <= '0;
      b_rd_addr   <= '0;
      a_row       <= '0;
      b_col       <= '0;
      b_base_r    <= '0;
      b_step      <= '0;
      transpose_r <= 1'b0;
      drain_cnt   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          a_rd_addr <= '0;
          b_rd_addr <= '0;
          if (start_valid) begin
            i_cnt       <= '0;
            j_cnt       <= '0;
            k_cnt       <= '0;
            i_max       <= cfg_rows_a - 1'b1;
            j_max       <= cfg_cols_b - 1'b1;
            k_max       <= cfg_cols_a - 1'b1;
            transpose_r <= cfg_transpose_b;
            b_step      <= cfg_transpose_b ? ADDR_W'(1) : ADDR_W'(cfg_cols_b);
            a_row       <= cfg_a_base;
            b_col       <= cfg_b_base;
            b_base_r    <= cfg_b_base;
            if (zero_dim) begin
              state <= DONE;
            end else begin
              state     <= RUN;
              a_rd_addr <= cfg_a_base;
              b_rd_addr <= cfg_b_base;
            end
          end
        end
        RUN: begin
          if (k_last && j_last && i_last) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end else if (!k_last) begin
            k_cnt     <= k_cnt + 1'b1;
            a_rd_addr <= a_rd_addr + 1'b1;
            b_rd_addr <= b_rd_addr + b_step;
          end else if (!j_last) begin
            k_cnt     <= '0;
            j_cnt     <= j_cnt + 1'b1;
            a_rd_addr <= a_row;
            b_rd_addr <= b_next_col;
            b_col     <= b_next_col;
          end else begin
            k_cnt     <= '0;
            j_cnt     <= '0;
            i_cnt     <= i_cnt + 1'b1;
            a_rd_addr <= a_rd_addr + 1'b1;
            a_row     <= a_rd_addr + 1'b1;
            b_rd_addr <= b_base_r;
            b_col     <= b_base_r;
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= DONE;
        end
        DONE: begin
          state     <= IDLE;
          a_rd_addr <= '0;
          b_rd_addr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign prod_u   = (2*DATA_W)'(a_rd_data) * (2*DATA_W)'(b_rd_data);
  assign prod_s   = (2*DATA_W)'($signed(a_rd_data)) * (2*DATA_W)'($signed(b_rd_data));
  assign prod_ext = (SIGNED != 0) ? ACC_W'(prod_s) : ACC_W'(prod_u);
  // First term of an element reloads the accumulator instead of adding to it.
  assign sum      = (p1_first ? '0 : acc) + prod_ext;

`ifdef ATTN_MATMUL_SAT_EN
  logic clamp;

  always_comb begin
    // NOTE: defaults before any branch keep this block free of inferred latches.
    out_val = sum[DATA_W-1:0];
    clamp   = 1'b0;
    if (SIGNED != 0) begin
      if ((sum[ACC_W-1:DATA_W-1] != '0) && (sum[ACC_W-1:DATA_W-1] != '1)) begin
        clamp   = 1'b1;
        out_val = sum[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end
    end else if (sum[ACC_W-1:DATA_W] != '0) begin
      clamp   = 1'b1;
      out_val = '1;
    end
  end
`else
  assign out_val  = sum[DATA_W-1:0];
  assign sat_flag = 1'b0;
`endif

  // Return stage: accumulate the returning pair, emit the element on its last k.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_valid  <= 1'b0;
      p1_first  <= 1'b0;
      p1_last   <= 1'b0;
      acc       <= '0;
      c_addr    <= '0;
      c_wr_en   <= 1'b0;
      c_wr_addr <= '0;
      c_wr_data <= '0;
`ifdef ATTN_MATMUL_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      p1_valid  <= (state == RUN);
      p1_first  <= (k_cnt == '0);
      p1_last   <= k_last;
      c_wr_en   <= 1'b0;
      c_wr_addr <= '0;
      c_wr_data <= '0;
      if (accept) begin
        c_addr   <= cfg_c_base;
`ifdef ATTN_MATMUL_SAT_EN
        sat_flag <= 1'b0;
`endif
      end
      if (p1_valid) begin
        acc <= sum;
        if (p1_last) begin
          c_wr_en   <= 1'b1;
          c_wr_addr <= c_addr;
          c_wr_data <= out_val;
          c_addr    <= c_addr + 1'b1;
`ifdef ATTN_MATMUL_SAT_EN
          if (clamp) sat_flag <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_attn_matmul_engine.sv
// Directed bench for attn_matmul_engine (DATA_W=8, unsigned) with 1-cycle SRAM models.
// Cycle numbers are relative to the cycle in which the job was accepted.
module tb_attn_matmul_engine;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;
  localparam int DIM_W  = 12;
  localparam int ACC_W  = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start_valid;
  logic              start_ready;
  logic [DIM_W-1:0]  cfg_rows_a, cfg_cols_a, cfg_cols_b;
  logic [ADDR_W-1:0] cfg_a_base, cfg_b_base, cfg_c_base;
  logic              cfg_transpose_b;
  logic [ADDR_W-1:0] a_rd_addr, b_rd_addr, c_wr_addr;
  logic [DATA_W-1:0] a_rd_data, b_rd_data, c_wr_data;
  logic              c_wr_en, busy, done, sat_flag;

  attn_matmul_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .ACC_W(ACC_W), .SIGNED(0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .cfg_rows_a(cfg_rows_a), .cfg_cols_a(cfg_cols_a), .cfg_cols_b(cfg_cols_b),
    .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base), .cfg_c_base(cfg_c_base),
    .cfg_transpose_b(cfg_transpose_b),
    .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .c_wr_en(c_wr_en), .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data),
    .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] a_mem [0:65535];
  logic [DATA_W-1:0] b_mem [0:65535];

  always @(posedge clk) begin
    a_rd_data <= a_mem[a_rd_addr];
    b_rd_data <= b_mem[b_rd_addr];
  end

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int done_cnt = 0;
  int done_rel = 0;
  int ndone    = 0;
  bit bad_idle = 1'b0;
  bit rd_nonzero = 1'b0;
  int wr_addr_q[$], wr_data_q[$], wr_cyc_q[$];
  int exp_addr[$], exp_data[$], exp_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor sampling mid-cycle.
  always @(negedge clk) begin
    if (start_valid && start_ready) acc_cyc = cyc;
    if (c_wr_en) begin
      wr_addr_q.push_back(int'(c_wr_addr));
      wr_data_q.push_back(int'(c_wr_data));
      wr_cyc_q.push_back(cyc - acc_cyc);
    end else if (c_wr_addr != '0 || c_wr_data != '0) begin
      bad_idle = 1'b1;
    end
    if (done) begin
      done_cnt++;
      done_rel = cyc - acc_cyc;
    end
    if (a_rd_addr != '0 || b_rd_addr != '0) rd_nonzero = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_wr(input int a, input int d, input int c);
    exp_addr.push_back(a);
    exp_data.push_back(d);
    exp_cyc.push_back(c);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, 64'(wr_addr_q.size()), 64'(exp_addr.size()));
    for (int n = 0; n < exp_addr.size() && n < wr_addr_q.size(); n++) begin
      check($sformatf("%s_addr%0d", tag, n), 64'(wr_addr_q[n]), 64'(exp_addr[n]));
      check($sformatf("%s_data%0d", tag, n), 64'(wr_data_q[n]), 64'(exp_data[n]));
      check($sformatf("%s_cyc%0d",  tag, n), 64'(wr_cyc_q[n]),  64'(exp_cyc[n]));
    end
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    exp_addr.delete();  exp_data.delete();  exp_cyc.delete();
  endtask

  task automatic set_cfg(input int m, input int k, input int p,
                         input int ab, input int bb, input int cb, input bit tr);
    cfg_rows_a      = m[DIM_W-1:0];
    cfg_cols_a      = k[DIM_W-1:0];
    cfg_cols_b      = p[DIM_W-1:0];
    cfg_a_base      = ab[ADDR_W-1:0];
    cfg_b_base      = bb[ADDR_W-1:0];
    cfg_c_base      = cb[ADDR_W-1:0];
    cfg_transpose_b = tr;
  endtask

  // One-cycle request; cfg is scrambled right after acceptance.
  task automatic start_job(input int m, input int k, input int p,
                           input int ab, input int bb, input int cb, input bit tr);
    @(posedge clk); #1;
    set_cfg(m, k, p, ab, bb, cb, tr);
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    set_cfg(3, 5, 7, 'hABCD, 'h1357, 'h2468, !tr);
  endtask

  task automatic wait_done(input string tag, input int target, input int exp_rel);
    int b = 0;
    while (done_cnt < target && b < 2000) begin
      @(negedge clk); #1;
      b++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt), 64'(target));
    check({tag, "_done_cyc"}, 64'(done_rel), 64'(exp_rel));
    check({tag, "_ready_in_done"}, 64'(start_ready), 64'(0));
    @(negedge clk); #1;
    check({tag, "_ready_after"}, 64'(start_ready), 64'(1));
    ndone = target;
  endtask

  task automatic load_2x2_normal();
    a_mem[0] = 1; a_mem[1] = 2; a_mem[2] = 3; a_mem[3] = 4;
    b_mem['h20] = 5; b_mem['h21] = 6; b_mem['h22] = 7; b_mem['h23] = 8;
  endtask

  task automatic expect_2x2();
    expect_wr('h40, 19, 4); expect_wr('h41, 22, 6);
    expect_wr('h42, 43, 8); expect_wr('h43, 50, 10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 65536; n++) begin
      a_mem[n] = '0;
      b_mem[n] = '0;
    end
    reset_n = 1'b0;
    start_valid = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 1'b0);
    #1;
    check("rst_start_ready", 64'(start_ready), 64'(1));
    check("rst_busy",        64'(busy),        64'(0));
    check("rst_done",        64'(done),        64'(0));
    check("rst_c_wr_en",     64'(c_wr_en),     64'(0));
    check("rst_a_rd_addr",   64'(a_rd_addr),   64'(0));
    check("rst_b_rd_addr",   64'(b_rd_addr),   64'(0));
    check("rst_sat_flag",    64'(sat_flag),    64'(0));
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;

    // 2x2x2 normal mode
    load_2x2_normal();
    expect_2x2();
    start_job(2, 2, 2, 0, 'h20, 'h40, 1'b0);
    wait_done("mm_norm", ndone + 1, 11);
    check_writes("mm_norm");

    // Same product with B stored transposed
    b_mem['h20] = 5; b_mem['h21] = 7; b_mem['h22] = 6; b_mem['h23] = 8;
    expect_2x2();
    start_job(2, 2, 2, 0, 'h20, 'h40, 1'b1);
    wait_done("mm_trans", ndone + 1, 11);
    check_writes("mm_trans");

    // 1x2 by 2x2 with A and C straddling the address wrap
    a_mem['hFFFF] = 2; a_mem[0] = 3;
    b_mem['h10] = 1; b_mem['h11] = 4; b_mem['h12] = 5; b_mem['h13] = 6;
    expect_wr('hFFFF, 17, 4); expect_wr('h0000, 26, 6);
    start_job(1, 2, 2, 'hFFFF, 'h10, 'hFFFF, 1'b0);
    wait_done("wrap", ndone + 1, 7);
    check_writes("wrap");

    // Zero dimension: no reads, no writes, immediate done
    rd_nonzero = 1'b0;
    start_job(0, 2, 2, 'h1234, 'h2345, 'h50, 1'b0);
    wait_done("zero", ndone + 1, 1);
    check_writes("zero");
    check("zero_no_reads", 64'(rd_nonzero), 64'(0));

    // 16*16 overflows an 8-bit result
    a_mem[0] = 16; b_mem[0] = 16;
`ifdef ATTN_MATMUL_SAT_EN
    expect_wr('h60, 255, 3);
`else
    expect_wr('h60, 0, 3);
`endif
    start_job(1, 1, 1, 0, 0, 'h60, 1'b0);
    wait_done("sat", ndone + 1, 4);
    check_writes("sat");
`ifdef ATTN_MATMUL_SAT_EN
    check("sat_flag_set", 64'(sat_flag), 64'(1));
`else
    check("sat_flag_set", 64'(sat_flag), 64'(0));
`endif

    // 1x1x1 with start_valid held: second accept only once start_ready returns
    a_mem[0] = 7; b_mem[0] = 6;
    expect_wr('h70, 42, 3); expect_wr('h70, 42, 3);
    @(posedge clk); #1;
    set_cfg(1, 1, 1, 0, 0, 'h70, 1'b0);
    start_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("held_ready_c%0d", c), 64'(start_ready), 64'(0));
    end
    @(posedge clk); #1;
    check("held_ready_c5", 64'(start_ready), 64'(1));
    @(posedge clk); #1;
    start_valid = 1'b0;
    wait_done("held", ndone + 2, 4);
    check_writes("held");
    check("sat_flag_cleared", 64'(sat_flag), 64'(0));

    // Reset pulse in the middle of a 4x4x4 job
    start_job(4, 4, 4, 0, 'h20, 'h80, 1'b0);
    repeat (19) @(posedge clk);
    #2;
    check("rst_mid_pre_writes", 64'(wr_addr_q.size()), 64'(4));
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    reset_n = 1'b0;
    #1;
    check("rst_mid_start_ready", 64'(start_ready), 64'(1));
    check("rst_mid_busy",        64'(busy),        64'(0));
    check("rst_mid_c_wr_en",     64'(c_wr_en),     64'(0));
    check("rst_mid_c_wr_addr",   64'(c_wr_addr),   64'(0));
    check("rst_mid_c_wr_data",   64'(c_wr_data),   64'(0));
    check("rst_mid_a_rd_addr",   64'(a_rd_addr),   64'(0));
    check("rst_mid_b_rd_addr",   64'(b_rd_addr),   64'(0));
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    check("rst_mid_no_writes", 64'(wr_addr_q.size()), 64'(0));
    check("rst_mid_no_done",   64'(done_cnt),         64'(ndone));

    // Clean job after the reset
    load_2x2_normal();
    expect_2x2();
    start_job(2, 2, 2, 0, 'h20, 'h40, 1'b0);
    wait_done("post_rst", ndone + 1, 11);
    check_writes("post_rst");

    check("idle_outputs_zero", 64'(bad_idle), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
